// File: rtl/array_pkg.sv
// Shared types and helpers for the masked read/write array.
package array_pkg;

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } ctrl_state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/array_rd_pipe.sv
// Read-return pipeline: RD_LAT registered stages carrying data plus valid.
// The last stage holds its data until a newer read arrives; flush empties it.
module array_rd_pipe #(
  parameter int WIDTH  = 126,
  parameter int RD_LAT = 1
) (
  input  logic             clk,
  input  logic             flush,
  input  logic             in_vld,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_vld,
  output logic [WIDTH-1:0] out_data
);

  logic [RD_LAT:0]              vld_pipe;
  logic [RD_LAT:0][WIDTH-1:0]   dat_pipe;
  logic [RD_LAT:1]              vld_d, vld_q;
  logic [RD_LAT:1][WIDTH-1:0]   dat_d, dat_q;

  assign vld_pipe = {vld_q, in_vld};
  assign dat_pipe = {dat_q, in_data};

  // Data only advances with a valid, so the output stage keeps the last read.
  always_comb begin
    vld_d = vld_pipe[RD_LAT-1:0];
    dat_d = dat_q;
    for (int s = 1; s <= RD_LAT; s++)
      if (vld_pipe[s-1]) dat_d[s] = dat_pipe[s-1];
  end

  always_ff @(posedge clk) begin
    if (flush) begin
      vld_q <= '0;
      dat_q <= '0;
    end else begin
      vld_q <= vld_d;
      dat_q <= dat_d;
    end
  end

  assign out_vld  = vld_q[RD_LAT] & ~flush;
  assign out_data = flush ? '0 : dat_q[RD_LAT];

endmodule

// File: rtl/array_rw_masked_ext.sv
// Single-port array with per-segment write mask and pipelined reads.
// Define ARRAY_CLEAR_EN to zero the whole array after every reset.
module array_rw_masked_ext
  import array_pkg::*;
#(
  parameter int DEPTH    = 256,
  parameter int WIDTH    = 126,
  parameter int MASK_SEG = 6,
  parameter int RD_LAT   = 1
) (
  input  logic                               RW0_clk,
  input  logic                               RW0_reset,
  input  logic [array_pkg::clog2(DEPTH)-1:0] RW0_addr,
  input  logic                               RW0_en,
  input  logic                               RW0_wmode,
  input  logic [MASK_SEG-1:0]                RW0_wmask,
  input  logic [WIDTH-1:0]                   RW0_wdata,
  output logic [WIDTH-1:0]                   RW0_rdata,
  output logic                               RW0_rvalid,
  output logic                               RW0_ready
);

  localparam int AW   = clog2(DEPTH);
  localparam int GRAN = WIDTH / MASK_SEG;

  if (WIDTH % MASK_SEG != 0) begin : g_bad_mask
    $error("WIDTH must be divisible by MASK_SEG");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("DEPTH must be a power of two >= 2");
  end
  if (RD_LAT != 1 && RD_LAT != 2) begin : g_bad_lat
    $error("RD_LAT must be 1 or 2");
  end

  logic [WIDTH-1:0]    mem_q [DEPTH];
  logic                ready;
  logic                acc, rd_acc;
  logic                clr_we;
  logic [AW-1:0]       clr_addr;
  logic                mem_we;
  logic [AW-1:0]       mem_addr;
  logic [MASK_SEG-1:0] mem_be;
  logic [WIDTH-1:0]    mem_wdata;

`ifdef ARRAY_CLEAR_EN
  ctrl_state_e   state_d, state_q;
  logic [AW-1:0] clr_cnt_d, clr_cnt_q;

  // Counter wraps to 0 on the same edge that hands over to RUN.
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    clr_we    = 1'b0;
    if (state_q == ST_CLEAR) begin
      clr_we    = ~RW0_reset;
      clr_cnt_d = clr_cnt_q + 1'b1;
      if (clr_cnt_q == AW'(DEPTH - 1)) state_d = ST_RUN;
    end
  end

  always_ff @(posedge RW0_clk) begin
    if (RW0_reset) begin
      state_q   <= ST_CLEAR;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  assign clr_addr = clr_cnt_q;
  assign ready    = (state_q == ST_RUN) & ~RW0_reset;
`else
  assign clr_we   = 1'b0;
  assign clr_addr = '0;
  assign ready    = ~RW0_reset;
`endif

  assign acc    = RW0_en & ready;
  assign rd_acc = acc & ~RW0_wmode;

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = RW0_addr;
    mem_be    = RW0_wmask;
    mem_wdata = RW0_wdata;
    if (clr_we) begin
      mem_we    = 1'b1;
      mem_addr  = clr_addr;
      mem_be    = '1;
      mem_wdata = '0;
    end else if (acc & RW0_wmode) begin
      mem_we    = 1'b1;
    end
  end

  always_ff @(posedge RW0_clk) begin
    for (int i = 0; i < MASK_SEG; i++)
      if (mem_we && mem_be[i])
        mem_q[mem_addr][i*GRAN +: GRAN] <= mem_wdata[i*GRAN +: GRAN];
  end

  // Read data is captured at the acceptance edge, so a following write cannot disturb it.
  array_rd_pipe #(
    .WIDTH  (WIDTH),
    .RD_LAT (RD_LAT)
  ) u_rd_pipe (
    .clk      (RW0_clk),
    .flush    (RW0_reset),
    .in_vld   (rd_acc),
    .in_data  (mem_q[RW0_addr]),
    .out_vld  (RW0_rvalid),
    .out_data (RW0_rdata)
  );

  assign RW0_ready = ready;

endmodule

// File: tb/tb_array_rw_masked_ext.sv
// Bench for array_rw_masked_ext: latency-1 and latency-2 instances share one
// stimulus stream and are checked against a queue-based behavioural model.
module tb_array_rw_masked_ext;

  localparam int DEPTH = 256;
  localparam int WIDTH = 126;
  localparam int SEG   = 6;
  localparam int GRAN  = WIDTH / SEG;
`ifdef ARRAY_CLEAR_EN
  localparam int CLR_CYC = DEPTH;
`else
  localparam int CLR_CYC = 0;
`endif

  logic             clk = 1'b0;
  logic             rst, en, wm;
  logic [7:0]       addr;
  logic [SEG-1:0]   mask;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] rdata1, rdata2;
  logic             rv1, rv2, rdy1, rdy2;

  always #5 clk = ~clk;

  array_rw_masked_ext #(.DEPTH(DEPTH), .WIDTH(WIDTH), .MASK_SEG(SEG), .RD_LAT(1)) dut (
    .RW0_clk(clk), .RW0_reset(rst), .RW0_addr(addr), .RW0_en(en), .RW0_wmode(wm),
    .RW0_wmask(mask), .RW0_wdata(wdata), .RW0_rdata(rdata1), .RW0_rvalid(rv1),
    .RW0_ready(rdy1));

  array_rw_masked_ext #(.DEPTH(DEPTH), .WIDTH(WIDTH), .MASK_SEG(SEG), .RD_LAT(2)) dut2 (
    .RW0_clk(clk), .RW0_reset(rst), .RW0_addr(addr), .RW0_en(en), .RW0_wmode(wm),
    .RW0_wmask(mask), .RW0_wdata(wdata), .RW0_rdata(rdata2), .RW0_rvalid(rv2),
    .RW0_ready(rdy2));

  typedef struct {
    int               due;
    logic [WIDTH-1:0] d;
  } rd_t;

  rd_t              q1[$];
  rd_t              q2[$];
  logic [WIDTH-1:0] mdl [DEPTH];
  logic [WIDTH-1:0] last1 = '0;
  logic [WIDTH-1:0] last2 = '0;
  int               cyc = 0;
  int               clr_left = 0;
  int               total = 0;
  int               npass = 0;

  task automatic chk(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
    total++;
    assert (obs === exp) npass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Check outputs mid-cycle, then advance the model on the rising edge.
  task automatic step();
    logic             exp_rdy, e1v, e2v;
    logic [WIDTH-1:0] e1d, e2d;
    @(negedge clk);
    exp_rdy = !rst && clr_left == 0;
    e1v = 1'b0;
    e2v = 1'b0;
    if (rst) begin
      e1d = '0;
      e2d = '0;
    end else begin
      if (q1.size() > 0 && q1[0].due == cyc) begin
        e1v = 1'b1; last1 = q1[0].d; void'(q1.pop_front());
      end
      if (q2.size() > 0 && q2[0].due == cyc) begin
        e2v = 1'b1; last2 = q2[0].d; void'(q2.pop_front());
      end
      e1d = last1;
      e2d = last2;
    end
    chk("ready_lat1", WIDTH'(rdy1), WIDTH'(exp_rdy));
    chk("ready_lat2", WIDTH'(rdy2), WIDTH'(exp_rdy));
    chk("rvalid_lat1", WIDTH'(rv1), WIDTH'(e1v));
    chk("rvalid_lat2", WIDTH'(rv2), WIDTH'(e2v));
    chk("rdata_lat1", rdata1, e1d);
    chk("rdata_lat2", rdata2, e2d);
    @(posedge clk);
    if (rst) begin
      q1.delete();
      q2.delete();
      last1 = '0;
      last2 = '0;
      clr_left = CLR_CYC;
    end else if (clr_left > 0) begin
      clr_left--;
      if (clr_left == 0) foreach (mdl[i]) mdl[i] = '0;
    end else if (en) begin
      if (wm) begin
        for (int s = 0; s < SEG; s++)
          if (mask[s]) mdl[addr][s*GRAN +: GRAN] = wdata[s*GRAN +: GRAN];
      end else begin
        q1.push_back('{cyc + 1, mdl[addr]});
        q2.push_back('{cyc + 2, mdl[addr]});
      end
    end
    cyc++;
    #1;
  endtask

  task automatic op(input logic e, input logic w, input logic [7:0] a,
                    input logic [SEG-1:0] m, input logic [WIDTH-1:0] d);
    en = e; wm = w; addr = a; mask = m; wdata = d;
    step();
  endtask

  task automatic idle();
    op(1'b0, 1'b0, 8'h00, '0, '0);
  endtask

  function automatic logic [WIDTH-1:0] rnd_word();
    logic [127:0] t;
    t = {$urandom, $urandom, $urandom, $urandom};
    return t[WIDTH-1:0];
  endfunction

  task automatic rnd_ops(input int n);
    logic [SEG-1:0] m;
    for (int i = 0; i < n; i++) begin
      m = ($urandom_range(0, 3) == 0) ? '0 : SEG'($urandom);
      op(1'($urandom_range(0, 3) != 0), 1'($urandom), 8'($urandom_range(0, 15)), m, rnd_word());
    end
  endtask

  logic [WIDTH-1:0] pat;

  initial begin
    rst = 1'b1; en = 1'b0; wm = 1'b0; addr = '0; mask = '0; wdata = '0;
    // Requests during reset and during the clear sweep must be dropped.
    repeat (3) op(1'b1, 1'b1, 8'($urandom), '1, rnd_word());
    rst = 1'b0;
    repeat (CLR_CYC) op(1'b1, 1'b1, 8'($urandom), '1, rnd_word());
`ifdef ARRAY_CLEAR_EN
    op(1'b1, 1'b0, 8'h00, '0, '0);
    op(1'b1, 1'b0, 8'hFF, '0, '0);
    idle(); idle();
`endif
    for (int a = 0; a < DEPTH; a++) op(1'b1, 1'b1, a[7:0], '1, rnd_word());

    // Masked write: segments 0 and 2 only.
    op(1'b1, 1'b1, 8'h10, '1, '0);
    op(1'b1, 1'b1, 8'h10, 6'b000101, '1);
    op(1'b1, 1'b0, 8'h10, '0, '0);
    pat = '0;
    pat[20:0]  = '1;
    pat[62:42] = '1;
    chk("masked_write_lat1", rdata1, pat);
    idle(); idle();
    chk("masked_write_lat2", rdata2, pat);

    // Back-to-back reads.
    op(1'b1, 1'b0, 8'h01, '0, '0);
    op(1'b1, 1'b0, 8'h02, '0, '0);
    op(1'b1, 1'b0, 8'h03, '0, '0);
    idle(); idle(); idle();

    // Read followed immediately by a write to the same word.
    op(1'b1, 1'b1, 8'h20, '1, WIDTH'(4'hA));
    op(1'b1, 1'b0, 8'h20, '0, '0);
    op(1'b1, 1'b1, 8'h20, '1, WIDTH'(4'hB));
    idle(); idle();
    chk("read_before_write_lat1", rdata1, WIDTH'(4'hA));
    chk("read_before_write_lat2", rdata2, WIDTH'(4'hA));
    op(1'b1, 1'b0, 8'h20, '0, '0);
    idle(); idle();
    chk("later_read_lat1", rdata1, WIDTH'(4'hB));
    chk("later_read_lat2", rdata2, WIDTH'(4'hB));

    rnd_ops(400);

    // A read one cycle before reset must never complete.
    op(1'b1, 1'b0, 8'h05, '0, '0);
    rst = 1'b1;
    idle(); idle();
    rst = 1'b0;
`ifdef ARRAY_CLEAR_EN
    repeat (100) op(1'b1, 1'b1, 8'($urandom), '1, rnd_word());
    rst = 1'b1;
    idle();
    rst = 1'b0;
    repeat (DEPTH) idle();
    op(1'b1, 1'b0, 8'h00, '0, '0);
    op(1'b1, 1'b0, 8'hFF, '0, '0);
    idle(); idle();
`endif
    op(1'b1, 1'b1, 8'h33, '1, rnd_word());
    op(1'b1, 1'b0, 8'h33, '0, '0);
    idle(); idle();
    rnd_ops(200);
    idle(); idle();

    $display("%0d/%0d checks passed", npass, total);
    $finish;
  end

endmodule

// File: doc/array_rw_masked_ext.md
ARRAY_RW_MASKED_EXT -- requirements
Module: array_rw_masked_ext

Interface
- REQ-001: Parameter DEPTH, default 256, number of words; power of two, >= 2.
- REQ-002: Parameter WIDTH, default 126, data bits per word.
- REQ-003: Parameter MASK_SEG, default 6, write-mask segments; WIDTH divisible by MASK_SEG; segment width GRAN = WIDTH/MASK_SEG.
- REQ-004: Parameter RD_LAT, default 1, read latency in cycles; legal values 1 or 2.
- REQ-005: RW0_clk  input  1  sole clock; all state changes on its rising edge.
- REQ-006: RW0_reset  input  1  synchronous, active-high reset.
- REQ-007: RW0_addr  input  log2(DEPTH)  word address.
- REQ-008: RW0_en  input  1  access request.
- REQ-009: RW0_wmode  input  1  1 = write, 0 = read.
- REQ-010: RW0_wmask  input  MASK_SEG  per-segment write enable; bit i covers bits [i*GRAN+GRAN-1 : i*GRAN].
- REQ-011: RW0_wdata  input  WIDTH  write data.
- REQ-012: RW0_rdata  output  WIDTH  registered read data.
- REQ-013: RW0_rvalid  output  1  one-cycle pulse marking new RW0_rdata.
- REQ-014: RW0_ready  output  1  array accepts requests.

Function
- REQ-015: An access is accepted only in a cycle where RW0_en && RW0_ready; requests with RW0_ready=0 are dropped, with no state change.
- REQ-016: Accepted write updates only the segments whose mask bit is 1; all-zero mask leaves memory unchanged and does not produce rvalid.
- REQ-017: Accepted read in cycle N drives RW0_rdata = mem[addr] and RW0_rvalid=1 in cycle N+RD_LAT; rvalid is 0 in all other cycles.
- REQ-018: Read data is sampled from the array at the acceptance edge; a write to the same address in cycle N+1 does not alter the in-flight or delivered data.
- REQ-019: RW0_rdata holds its last delivered value until the next read completes; writes never change RW0_rdata.
- REQ-020: Back-to-back reads in consecutive cycles are fully pipelined: one rvalid per cycle, in order.
- REQ-021: Controller states: CLEAR (ready=0) and RUN (ready=1); CLEAR -> RUN after the final clear write; RUN is left only by reset.
- REQ-022: In CLEAR, a counter writes all-zero words to addresses 0,1,...,DEPTH-1, one per cycle, so CLEAR lasts exactly DEPTH cycles.
- REQ-023: Counter wraps from DEPTH-1 to 0 on the transition to RUN; no address is skipped or repeated.

Reset
- REQ-024: While RW0_reset=1: RW0_rdata=0, RW0_rvalid=0, read pipeline flushed (in-flight reads discarded), counter=0.
- REQ-025: Reset asserted mid-CLEAR restarts the sweep at address 0 on the first cycle after reset releases.
- REQ-026: Memory contents are not reset directly; only the CLEAR sweep (if compiled in) initialises them.

Configuration
- REQ-027: Macro ARRAY_CLEAR_EN defined: after reset the controller enters CLEAR per REQ-021..REQ-025.
- REQ-028: ARRAY_CLEAR_EN undefined: no CLEAR state or counter; RW0_ready=0 only while RW0_reset=1 and 1 from the first cycle after release; memory contents undefined until written.

Structure
- REQ-029: Shared package array_pkg holds the controller state enum (CLEAR, RUN) and a clog2 helper function used for the address width.
- REQ-030: Read pipeline lives in sub-module array_rd_pipe (parameters WIDTH, RD_LAT; carries data plus valid bit; flush on reset).
- REQ-031: Elaboration error if WIDTH % MASK_SEG != 0, DEPTH is not a power of two, or RD_LAT is not 1 or 2.

Verification
- REQ-032: ARRAY_CLEAR_EN, DEPTH=256: release reset -> ready=0 for exactly 256 cycles, then 1; reading address 0x00 and 0xFF returns 0.
- REQ-033: Defaults, write addr 0x10 with wdata all-ones and mask 6'b000101 -> read of 0x10 returns bits [20:0] and [62:42] set, all others 0.
- REQ-034: RD_LAT=2, reads to 0x01,0x02,0x03 in cycles 0,1,2 -> rvalid in cycles 2,3,4 with matching data, in order.
- REQ-035: Read 0x20 (holds 0xA) in cycle N, write 0xB to 0x20 in cycle N+1 -> rdata=0xA at N+RD_LAT and stays 0xA; a later read returns 0xB.
- REQ-036: Assert reset at clear address 100 -> sweep restarts at 0 and takes 256 cycles; a read issued one cycle before reset never produces rvalid.
- REQ-037: ARRAY_CLEAR_EN undefined -> ready=1 in the first cycle after reset release; a write followed by a read of the same address returns the written data.
